// File: rtl/game_state_ctrl.sv
// Game flow controller: start/level-select/idle/play/pause/respawn/result screens plus snake step pulse.
// Latency: state, outputs and step_tick are registered; every button edge acts on the next clock edge.
// Backpressure: none; button presses are one-shot edges, lost/won are sampled only while playing.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   btnc, left, right        debounced button levels (rising edge = one action)
//   lost, won                collision / target-length flags from the snake logic
//   state                    0 START, 1 CHOOSE, 2 IDLE, 3 PLAY, 4 PAUSE, 5 RESULT, 6 RESPAWN
//   level, mov_speed         selected level and latched step period in cycles
//   lives_left, result_win   remaining lives and outcome of the last game
//   step_tick                one-cycle pulse per step period while in PLAY
module game_state_ctrl #(
    parameter int NUM_LEVELS     = 3,
    parameter int SPEED_W        = 28,
    parameter int SPEED_BASE     = 50_000_000,
    parameter int LIVES          = 3,
    parameter int RESULT_TIMEOUT = 500_000_000,
    localparam int LVL_W         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnc,
    input  logic               left,
    input  logic               right,
    input  logic               lost,
    input  logic               won,
    output logic [2:0]         state,
    output logic [LVL_W-1:0]   level,
    output logic [SPEED_W-1:0] mov_speed,
    output logic [3:0]         lives_left,
    output logic               step_tick,
    output logic               result_win
);

    localparam int RES_W = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;

    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(SPEED_BASE);
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [LVL_W-1:0]   LVL_MAX    = LVL_W'(NUM_LEVELS - 1);
    localparam logic [RES_W-1:0]   RES_LAST   = RES_W'(RESULT_TIMEOUT - 1);

    // The fastest level must still have a period of at least two cycles so the
    // tick stays a clean one-cycle pulse.
    if ((SPEED_BASE >> (NUM_LEVELS - 1)) < 2) begin : g_speed_chk
        $error("game_state_ctrl: SPEED_BASE >> (NUM_LEVELS-1) must be >= 2");
    end
    if (LIVES < 1 || LIVES > 15) begin : g_lives_chk
        $error("game_state_ctrl: LIVES must be in 1..15");
    end

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_CHOOSE  = 3'd1,
        ST_IDLE    = 3'd2,
        ST_PLAY    = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_RESULT  = 3'd5,
        ST_RESPAWN = 3'd6
    } state_t;

    state_t             cur, nxt;
    logic [2:0]         btn_q;       // previous levels of {btnc, left, right}
    logic               armed;       // low for the first cycle after reset
    logic [SPEED_W-1:0] step_cnt;
    logic [RES_W-1:0]   res_cnt;

    logic               edge_c, edge_l, edge_r;
    logic               press_c, press_l, press_r;
    logic [LVL_W-1:0]   level_n;
    logic [SPEED_W-1:0] speed_n;
    logic [3:0]         lives_n;
    logic               win_n;
    logic               step_clr;
    logic               step_wrap;
    logic               tick_n;

    assign state = cur;

    // Edges are masked until one cycle after reset has refreshed btn_q, so a
    // button held through reset never registers as a press.
    assign edge_c = armed & btnc  & ~btn_q[2];
    assign edge_l = armed & left  & ~btn_q[1];
    assign edge_r = armed & right & ~btn_q[0];

    assign press_c = edge_c;
    assign press_l = edge_l & ~edge_c;
    assign press_r = edge_r & ~edge_c & ~edge_l;

    assign step_wrap = (step_cnt >= mov_speed - SPEED_W'(1));

    always_comb begin
        nxt      = cur;
        level_n  = level;
        speed_n  = mov_speed;
        lives_n  = lives_left;
        win_n    = result_win;
        step_clr = 1'b0;
        tick_n   = 1'b0;
        case (cur)
            ST_START: begin
                if (press_c) nxt = ST_CHOOSE;
            end
            ST_CHOOSE: begin
                if (press_c) begin
                    speed_n = SPEED_INIT >> level;
                    lives_n = LIVES_INIT;
                    nxt     = ST_IDLE;
                end else if (press_l) begin
                    if (level != '0) level_n = level - LVL_W'(1);
                end else if (press_r) begin
                    if (level != LVL_MAX) level_n = level + LVL_W'(1);
                end
            end
            ST_IDLE, ST_RESPAWN: begin
                if (press_c) begin
                    nxt      = ST_PLAY;
                    step_clr = 1'b1;
                end
            end
            ST_PLAY: begin
                if (lost) begin
                    if (lives_left > 4'd1) begin
                        lives_n = lives_left - 4'd1;
                        nxt     = ST_RESPAWN;
                    end else begin
                        lives_n = 4'd0;
                        win_n   = 1'b0;
                        nxt     = ST_RESULT;
                    end
                end else if (won) begin
                    win_n = 1'b1;
                    nxt   = ST_RESULT;
                end else if (press_c) begin
                    nxt = ST_PAUSE;
                end
                // Suppress the tick when leaving PLAY so it never shows up
                // alongside another screen.
                tick_n = step_wrap && (nxt == ST_PLAY);
            end
            ST_PAUSE: begin
                if (press_c) nxt = ST_PLAY;
            end
            ST_RESULT: begin
                if (press_c || res_cnt == RES_LAST) nxt = ST_START;
            end
            default: begin
                nxt = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= ST_START;
            level      <= '0;
            mov_speed  <= SPEED_INIT;
            lives_left <= LIVES_INIT;
            step_tick  <= 1'b0;
            result_win <= 1'b0;
            step_cnt   <= '0;
            res_cnt    <= '0;
            btn_q      <= '0;
            armed      <= 1'b0;
        end else begin
            cur        <= nxt;
            level      <= level_n;
            mov_speed  <= speed_n;
            lives_left <= lives_n;
            step_tick  <= tick_n;
            result_win <= win_n;
            btn_q      <= {btnc, left, right};
            armed      <= 1'b1;
            // The counter also advances in the cycle PLAY is left for PAUSE,
            // and holds its value while paused.
            if (step_clr) begin
                step_cnt <= '0;
            end else if (cur == ST_PLAY) begin
                step_cnt <= step_wrap ? '0 : step_cnt + SPEED_W'(1);
            end
            // Zero whenever not staying in RESULT, so it starts at 0 on entry.
            res_cnt <= (cur == ST_RESULT && nxt == ST_RESULT) ? res_cnt + RES_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

    localparam int NL = 3;
    localparam int SW = 28;
    localparam int SB = 16;
    localparam int LV = 2;
    localparam int RT = 20;

    localparam int S_START   = 0;
    localparam int S_CHOOSE  = 1;
    localparam int S_IDLE    = 2;
    localparam int S_PLAY    = 3;
    localparam int S_PAUSE   = 4;
    localparam int S_RESULT  = 5;
    localparam int S_RESPAWN = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btnc = 1'b0, left = 1'b0, right = 1'b0, lost = 1'b0, won = 1'b0;
    logic [2:0]    state;
    logic [1:0]    level;
    logic [SW-1:0] mov_speed;
    logic [3:0]    lives_left;
    logic          step_tick;
    logic          result_win;

    int n_checks = 0;
    int n_fail   = 0;
    int e_lvl, e_spd, e_lives, e_win;

    game_state_ctrl #(
        .NUM_LEVELS(NL), .SPEED_W(SW), .SPEED_BASE(SB), .LIVES(LV), .RESULT_TIMEOUT(RT)
    ) dut (
        .clk(clk), .rst(rst), .btnc(btnc), .left(left), .right(right),
        .lost(lost), .won(won), .state(state), .level(level), .mov_speed(mov_speed),
        .lives_left(lives_left), .step_tick(step_tick), .result_win(result_win)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pk(input int st, input int lv, input int sp,
                                       input int li, input int tk, input int wn);
        return {25'd0, 3'(st), 2'(lv), 28'(sp), 4'(li), 1'(tk), 1'(wn)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (st/lvl/spd/lives/tick/win)", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input int st, input int tk);
        check(name, pk(state, level, mov_speed, lives_left, step_tick, result_win),
              pk(st, e_lvl, e_spd, e_lives, tk, e_win));
    endtask

    task automatic drive(input logic [4:0] v);
        {btnc, left, right, lost, won} = v;
    endtask

    // One press cycle followed by one release cycle.
    task automatic pulse(input logic [4:0] v);
        drive(v);
        step();
        drive(5'b0);
        step();
    endtask

    // Reference model: screen flow from the rules, step ticks from the total
    // number of cycles spent playing since the last fresh start.
    int       m_state, m_level, m_speed, m_lives, m_tick, m_win, m_played, m_res_age;
    logic [2:0] m_prev;

    task automatic model_reset();
        m_state = S_START; m_level = 0; m_speed = SB; m_lives = LV;
        m_tick = 0; m_win = 0; m_played = 0; m_res_age = 0;
        m_prev = 3'b111;   // levels seen at reset count as already held
    endtask

    task automatic model_step();
        logic [2:0] e;
        logic pc, pl, pr;
        int ns;
        if (rst) begin
            model_reset();
            return;
        end
        e = {btnc, left, right} & ~m_prev;
        m_prev = {btnc, left, right};
        pc = e[2];
        pl = e[1] & ~pc;
        pr = e[0] & ~pc & ~e[1];
        ns = m_state;
        m_tick = 0;
        case (m_state)
            S_START:  if (pc) ns = S_CHOOSE;
            S_CHOOSE: begin
                if (pc) begin
                    m_speed = SB / (2 ** m_level);
                    m_lives = LV;
                    ns = S_IDLE;
                end else if (pl) begin
                    if (m_level > 0) m_level--;
                end else if (pr) begin
                    if (m_level < NL - 1) m_level++;
                end
            end
            S_IDLE, S_RESPAWN: if (pc) begin ns = S_PLAY; m_played = 0; end
            S_PLAY: begin
                m_played++;
                if (lost) begin
                    if (m_lives > 1) begin m_lives--; ns = S_RESPAWN; end
                    else begin m_lives = 0; m_win = 0; ns = S_RESULT; end
                end else if (won) begin
                    m_win = 1; ns = S_RESULT;
                end else if (pc) ns = S_PAUSE;
                if (ns == S_PLAY && (m_played % m_speed) == 0) m_tick = 1;
            end
            S_PAUSE: if (pc) ns = S_PLAY;
            S_RESULT: begin
                m_res_age++;
                if (pc || m_res_age == RT) ns = S_START;
            end
            default: ns = S_START;
        endcase
        if (ns == S_RESULT && m_state != S_RESULT) m_res_age = 0;
        m_state = ns;
    endtask

    typedef struct {
        logic [4:0] in;   // {btnc, left, right, lost, won}
        int         st;
        int         lvl;
        int         spd;
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{5'b10000, S_START,  0, 16};   // held through reset: ignored
        tbl[1]  = '{5'b00000, S_START,  0, 16};
        tbl[2]  = '{5'b10000, S_CHOOSE, 0, 16};
        tbl[3]  = '{5'b00000, S_CHOOSE, 0, 16};
        tbl[4]  = '{5'b00100, S_CHOOSE, 1, 16};
        tbl[5]  = '{5'b00000, S_CHOOSE, 1, 16};
        tbl[6]  = '{5'b00100, S_CHOOSE, 2, 16};
        tbl[7]  = '{5'b00000, S_CHOOSE, 2, 16};
        tbl[8]  = '{5'b00100, S_CHOOSE, 2, 16};   // saturates at top
        tbl[9]  = '{5'b00000, S_CHOOSE, 2, 16};
        tbl[10] = '{5'b01000, S_CHOOSE, 1, 16};
        tbl[11] = '{5'b00000, S_CHOOSE, 1, 16};
        tbl[12] = '{5'b00011, S_CHOOSE, 1, 16};   // lost/won ignored outside PLAY
        tbl[13] = '{5'b01100, S_CHOOSE, 0, 16};   // left beats right
        tbl[14] = '{5'b00000, S_CHOOSE, 0, 16};
        tbl[15] = '{5'b00100, S_CHOOSE, 1, 16};
        tbl[16] = '{5'b00000, S_CHOOSE, 1, 16};
        tbl[17] = '{5'b11000, S_IDLE,   1, 8};    // btnc beats left
        tbl[18] = '{5'b00000, S_IDLE,   1, 8};
        tbl[19] = '{5'b01100, S_IDLE,   1, 8};    // arrows do nothing in IDLE

        e_lvl = 0; e_spd = 16; e_lives = 2; e_win = 0;

        // Reset with btnc held.
        rst = 1'b1; btnc = 1'b1;
        step();
        step();
        chk("reset", S_START, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            step();
            e_lvl = tbl[i].lvl;
            e_spd = tbl[i].spd;
            chk($sformatf("tbl%0d", i), tbl[i].st, 0);
        end
        drive(5'b0);
        step();

        // IDLE -> PLAY, pause at cycle 11, resume at cycle 30, lost ignored while paused.
        btnc = 1'b1; step(); btnc = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            chk($sformatf("play1_c%0d", k),
                (k <= 11) ? S_PLAY : (k <= 30) ? S_PAUSE : S_PLAY,
                (k == 8 || k == 35) ? 1 : 0);
            btnc = (k == 11 || k == 30);
            lost = (k == 20);
            step();
        end
        drive(5'b0);

        // Lose a life.
        lost = 1'b1; step(); lost = 1'b0;
        e_lives = 1;
        chk("respawn", S_RESPAWN, 0);

        // RESPAWN -> PLAY restarts the period; then lost+won together on the last life.
        btnc = 1'b1; step(); btnc = 1'b0;
        for (int k = 0; k <= 25; k++) begin
            chk($sformatf("play2_c%0d", k), S_PLAY, (k > 0 && k % 8 == 0) ? 1 : 0);
            if (k == 25) begin lost = 1'b1; won = 1'b1; end
            step();
        end
        drive(5'b0);
        e_lives = 0; e_win = 0;
        chk("result_lost", S_RESULT, 0);

        // Result screen times out exactly 20 cycles after entry.
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("timeout_c%0d", k), (k < 20) ? S_RESULT : S_START, 0);
        end

        // Level is kept across games; won path.
        pulse(5'b10000);
        chk("choose_keep_lvl", S_CHOOSE, 0);
        pulse(5'b10000);
        e_lives = 2;
        chk("idle2", S_IDLE, 0);
        pulse(5'b10000);
        chk("play3", S_PLAY, 0);
        pulse(5'b00001);
        e_win = 1;
        chk("result_won", S_RESULT, 0);
        pulse(5'b10000);
        chk("result_btn", S_START, 0);

        // Reset while paused.
        pulse(5'b10000);
        pulse(5'b10000);
        pulse(5'b10000);
        pulse(5'b10000);
        chk("pause", S_PAUSE, 0);
        rst = 1'b1; step(); rst = 1'b0;
        e_lvl = 0; e_spd = 16; e_lives = 2; e_win = 0;
        chk("rst_pause", S_START, 0);
        step();

        // Reset in the cycle a tick is due leaves no tick behind.
        pulse(5'b10000);
        pulse(5'b10000);
        btnc = 1'b1; step(); btnc = 1'b0;
        repeat (15) step();
        chk("pre_rst_tick", S_PLAY, 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_tick", S_START, 0);

        // Randomized stimulus against the reference model.
        rst = 1'b1; step(); rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            btnc  = ($urandom_range(0, 3) == 0);
            left  = ($urandom_range(0, 3) == 0);
            right = ($urandom_range(0, 3) == 0);
            lost  = ($urandom_range(0, 24) == 0);
            won   = ($urandom_range(0, 49) == 0);
            model_step();
            step();
            check($sformatf("rand%0d", i),
                  pk(state, level, mov_speed, lives_left, step_tick, result_win),
                  pk(m_state, m_level, m_speed, m_lives, m_tick, m_win));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
